// File: rtl/light_pkg.sv
// Shared types and constants for the traffic light sequencer.
// Phase codes, FSM states, timer width and default phase durations.
package light_pkg;

  localparam int TIMER_W = 6;

  localparam int RED_TIME_DEF    = 18;
  localparam int GREEN_TIME_DEF  = 15;
  localparam int YELLOW_TIME_DEF = 3;
  localparam int PED_SHORT_DEF   = 5;

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_RED:   return PH_GREEN;
      PH_GREEN: return PH_YELLOW;
      default:  return PH_RED;
    endcase
  endfunction

endpackage

// File: rtl/lamp_decoder.sv
// Registered one-hot lamp drive from the next-phase value, so the lamps
// switch on the same edge as the phase register.
module lamp_decoder
  import light_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  phase_t phase_nxt,
  output logic   red,
  output logic   yellow,
  output logic   green
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red    <= 1'b1;
      yellow <= 1'b0;
      green  <= 1'b0;
    end else begin
      case (phase_nxt)
        PH_GREEN: begin
          red    <= 1'b0;
          yellow <= 1'b0;
          green  <= 1'b1;
        end
        PH_YELLOW: begin
          red    <= 1'b0;
          yellow <= 1'b1;
          green  <= 1'b0;
        end
        default: begin
          red    <= 1'b1;
          yellow <= 1'b0;
          green  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/light_sequencer.sv
// Traffic light phase sequencer driving an external down-counter.
// Optional pedestrian request handling is enabled with `define PED_REQ_EN.
//
// state | meaning
// IDLE  | parked, phase held; enable loads the current phase duration
// ARM   | one cycle while the counter takes the load; counter ignored
// RUN   | waiting for counter_value to reach 0
module light_sequencer
  import light_pkg::*;
#(
  parameter int RED_TIME    = RED_TIME_DEF,
  parameter int GREEN_TIME  = GREEN_TIME_DEF,
  parameter int YELLOW_TIME = YELLOW_TIME_DEF
`ifdef PED_REQ_EN
  , parameter int PED_SHORT = PED_SHORT_DEF
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [TIMER_W-1:0] counter_value,
`ifdef PED_REQ_EN
  input  logic               ped_req,
  output logic               walk,
`endif
  output logic [TIMER_W-1:0] timer_value,
  output logic               load,
  output logic               red,
  output logic               yellow,
  output logic               green,
  output logic [1:0]         phase
);

  localparam logic [TIMER_W-1:0] RED_T    = TIMER_W'(RED_TIME);
  localparam logic [TIMER_W-1:0] GREEN_T  = TIMER_W'(GREEN_TIME);
  localparam logic [TIMER_W-1:0] YELLOW_T = TIMER_W'(YELLOW_TIME);

  state_t             state_q, state_d;
  phase_t             phase_q, phase_d;
  logic               load_q, load_d;
  logic [TIMER_W-1:0] tv_q, tv_d;

  function automatic logic [TIMER_W-1:0] phase_dur(input phase_t p);
    case (p)
      PH_GREEN:  return GREEN_T;
      PH_YELLOW: return YELLOW_T;
      default:   return RED_T;
    endcase
  endfunction

`ifdef PED_REQ_EN
  localparam logic [TIMER_W-1:0] PED_T = TIMER_W'(PED_SHORT);

  logic ped_q, ped_d;
  logic short_q, short_d;
  logic walk_q, walk_d;
  logic red_entry;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= PH_RED;
      load_q  <= 1'b0;
      tv_q    <= RED_T;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      load_q  <= load_d;
      tv_q    <= tv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    load_d  = 1'b0;
    tv_d    = tv_q;
`ifdef PED_REQ_EN
    short_d = short_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          load_d  = 1'b1;
          tv_d    = phase_dur(phase_q);
          state_d = ST_ARM;
        end
      end
      ST_ARM: begin
        state_d = enable ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (counter_value == '0) begin
          phase_d = next_phase(phase_q);
          load_d  = 1'b1;
          tv_d    = phase_dur(phase_d);
          state_d = ST_ARM;
`ifdef PED_REQ_EN
          short_d = 1'b0;
        end else if (phase_q == PH_GREEN && ped_q && !short_q &&
                     counter_value > PED_T) begin
          // Cut the remaining green short once; phase is unchanged.
          load_d  = 1'b1;
          tv_d    = PED_T;
          state_d = ST_ARM;
          short_d = 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PED_REQ_EN
  always_comb begin
    red_entry = (phase_d == PH_RED) && (phase_q != PH_RED);
    ped_d     = (ped_q && !red_entry) || ped_req;
    walk_d    = 1'b0;
    if (red_entry)
      walk_d = ped_q;
    else if (phase_d == PH_RED)
      walk_d = walk_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ped_q   <= 1'b0;
      short_q <= 1'b0;
      walk_q  <= 1'b0;
    end else begin
      ped_q   <= ped_d;
      short_q <= short_d;
      walk_q  <= walk_d;
    end
  end

  assign walk = walk_q;
`endif

  lamp_decoder u_lamp (
    .clk       (clk),
    .reset     (reset),
    .phase_nxt (phase_d),
    .red       (red),
    .yellow    (yellow),
    .green     (green)
  );

  assign timer_value = tv_q;
  assign load        = load_q;
  assign phase       = phase_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Self-checking bench for light_sequencer with an attached down-counter model.
// Pedestrian sequences are exercised only when PED_REQ_EN is defined.
module tb_light_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [5:0] counter_value = '0;
  logic [5:0] timer_value;
  logic       load, red, yellow, green;
  logic [1:0] phase;
`ifdef PED_REQ_EN
  logic       ped_req;
  logic       walk;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  light_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .counter_value (counter_value),
`ifdef PED_REQ_EN
    .ped_req       (ped_req),
    .walk          (walk),
`endif
    .timer_value   (timer_value),
    .load          (load),
    .red           (red),
    .yellow        (yellow),
    .green         (green),
    .phase         (phase)
  );

  // External counter: loads on a sampled load pulse, then counts down to 0.
  always @(posedge clk) begin
    if (load)
      counter_value <= timer_value;
    else if (counter_value != 6'd0)
      counter_value <= counter_value - 6'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: each phase occupies duration+2 cycles counted from its load.
  int         dur_tab [3] = '{18, 15, 3};
  bit         chk_on = 1'b0;
  bit         m_run = 1'b0;
  int         m_ph = 0;
  int         m_left = 0;
  bit         m_load = 1'b0;
  logic [5:0] m_tv = 6'd18;
  logic       prev_load = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_run = 1'b0; m_ph = 0; m_load = 1'b0; m_tv = 6'd18;
    end else if (!m_run) begin
      if (enable) begin
        m_run = 1'b1; m_load = 1'b1;
        m_tv = 6'(dur_tab[m_ph]); m_left = dur_tab[m_ph] + 1;
      end else begin
        m_load = 1'b0;
      end
    end else if (!enable) begin
      m_run = 1'b0; m_load = 1'b0;
    end else if (m_left == 0) begin
      m_ph = (m_ph + 1) % 3; m_load = 1'b1;
      m_tv = 6'(dur_tab[m_ph]); m_left = dur_tab[m_ph] + 1;
    end else begin
      m_left--; m_load = 1'b0;
    end
    #1;
    if (chk_on) begin
      check("model_cycle", 32'({load, timer_value, phase, red, yellow, green}),
            32'({m_load, m_tv, m_ph[1:0], m_ph == 0, m_ph == 2, m_ph == 1}));
      check("load_back_to_back", 32'(load & prev_load), 32'd0);
    end
    prev_load = load;
  end

  task automatic wait_load(output logic [5:0] tv, output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!load && n < 200);
    if (!load) begin
      total++; bad++;
      $display("FAIL wait_load: no load within %0d cycles", n);
    end
    tv = timer_value;
  endtask

  task automatic wait_cv(input logic [5:0] v);
    int n = 0;
    while (!(counter_value == v && phase == 2'd1) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL wait_cv: counter_value %0d in GREEN not seen", v);
    end
  endtask

  typedef struct {
    bit         rst;
    bit         en;
    bit         exp_load;
    logic [5:0] exp_tv;
    logic [1:0] exp_ph;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [5:0] tv;
    int         n;
    reset  = 1'b1;
    enable = 1'b0;
`ifdef PED_REQ_EN
    ped_req = 1'b0;
`endif
    vt[0] = '{1'b1, 1'b0, 1'b0, 6'd18, 2'd0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 6'd18, 2'd0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 6'd18, 2'd0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 6'd18, 2'd0};
    vt[4] = '{1'b0, 1'b1, 1'b1, 6'd18, 2'd0};
    vt[5] = '{1'b0, 1'b1, 1'b0, 6'd18, 2'd0};
    vt[6] = '{1'b0, 1'b1, 1'b0, 6'd18, 2'd0};
    vt[7] = '{1'b0, 1'b0, 1'b0, 6'd18, 2'd0};
    vt[8] = '{1'b0, 1'b1, 1'b1, 6'd18, 2'd0};
    vt[9] = '{1'b0, 1'b1, 1'b0, 6'd18, 2'd0};

    @(negedge clk);
    chk_on = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      reset  = vt[i].rst;
      enable = vt[i].en;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 32'({load, timer_value, phase, red, yellow, green}),
            32'({vt[i].exp_load, vt[i].exp_tv, vt[i].exp_ph,
                 vt[i].exp_ph == 2'd0, vt[i].exp_ph == 2'd2, vt[i].exp_ph == 2'd1}));
    end

    // Full cycle: RED (already loaded one cycle ago), GREEN, YELLOW, RED.
    wait_load(tv, n);
    check("first_green_tv", 32'({tv, phase}), 32'({6'd15, 2'd1}));
    check("red_len", 32'(n), 32'd19);
    wait_load(tv, n);
    check("yellow_tv", 32'({tv, phase}), 32'({6'd3, 2'd2}));
    check("green_len", 32'(n), 32'd17);
    wait_load(tv, n);
    check("red_tv", 32'({tv, phase}), 32'({6'd18, 2'd0}));
    check("yellow_len", 32'(n), 32'd5);
    wait_load(tv, n);
    check("green_tv", 32'({tv, phase}), 32'({6'd15, 2'd1}));
    check("red_full_len", 32'(n), 32'd20);

    // Pause in GREEN, then resume with a full GREEN reload.
    repeat (3) @(posedge clk);
    @(negedge clk); enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("green_hold", 32'({green, load, phase}), 32'({1'b1, 1'b0, 2'd1}));
    end
    @(negedge clk); enable = 1'b1;
    @(posedge clk); #1;
    check("resume_load", 32'({load, timer_value, phase}), 32'({1'b1, 6'd15, 2'd1}));
    wait_load(tv, n);
    check("resume_yellow", 32'({tv, phase}), 32'({6'd3, 2'd2}));
    check("resume_green_len", 32'(n), 32'd17);

    // Asynchronous reset in the middle of YELLOW.
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_reset_lamps", 32'({red, yellow, green, phase, load}),
          32'({1'b1, 1'b0, 1'b0, 2'd0, 1'b0}));
    @(posedge clk);
    @(negedge clk); reset = 1'b0;
    wait_load(tv, n);
    check("post_reset_tv", 32'({tv, phase}), 32'({6'd18, 2'd0}));

    // Random enable and reset activity against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 24) == 0) enable = ~enable;
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk); reset = 1'b0;

`ifdef PED_REQ_EN
    chk_on = 1'b0;
    @(negedge clk); reset = 1'b1; enable = 1'b0;
    @(negedge clk); reset = 1'b0; enable = 1'b1;
    wait_load(tv, n);
    check("ped_red_tv", 32'(tv), 32'd18);
    wait_load(tv, n);
    check("ped_green_tv", 32'({tv, phase}), 32'({6'd15, 2'd1}));
    wait_cv(6'd12);
    ped_req = 1'b1;
    @(posedge clk); #1; ped_req = 1'b0;
    wait_load(tv, n);
    check("ped_short_tv", 32'({tv, phase}), 32'({6'd5, 2'd1}));
    wait_load(tv, n);
    check("ped_short_yellow", 32'({tv, phase}), 32'({6'd3, 2'd2}));
    check("ped_short_len", 32'(n), 32'd7);
    wait_load(tv, n);
    check("ped_walk_red", 32'({tv, phase}), 32'({6'd18, 2'd0}));
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (walk) n++;
      @(posedge clk); #1;
    end
    check("walk_cycles", 32'(n), 32'd20);
    check("walk_off_green", 32'({load, phase, walk}), 32'({1'b1, 2'd1, 1'b0}));
    wait_cv(6'd4);
    ped_req = 1'b1;
    @(posedge clk); #1; ped_req = 1'b0;
    wait_load(tv, n);
    check("late_ped_no_short", 32'({tv, phase}), 32'({6'd3, 2'd2}));
    wait_load(tv, n);
    check("late_ped_walk", 32'({tv, phase, walk}), 32'({6'd18, 2'd0, 1'b1}));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/light_sequencer.md
LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 Parameter RED_TIME, default 18, RED phase duration in counter ticks; legal range 1..63.
REQ-002 Parameter GREEN_TIME, default 15, GREEN phase duration in counter ticks; legal range 1..63.
REQ-003 Parameter YELLOW_TIME, default 3, YELLOW phase duration in counter ticks; legal range 1..63.
REQ-004 Parameter PED_SHORT, default 5, shortened GREEN remainder in ticks; used only with PED_REQ_EN.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  run request; low parks the sequencer in IDLE.
REQ-008 counter_value  input  6  current down-count value from the counter block.
REQ-009 timer_value  output  6  duration presented to the counter; registered.
REQ-010 load  output  1  one-cycle pulse; counter loads timer_value on the same edge.
REQ-011 red, yellow, green  output  1 each  lamp drives, one-hot, registered.
REQ-012 phase  output  2  current phase code: RED=0, GREEN=1, YELLOW=2; 3 is unused.

Function
REQ-013 Counter contract: load sampled high at an edge gives counter_value=timer_value next cycle, then decrements by 1 per cycle and holds at 0.
REQ-014 FSM states: IDLE, ARM, RUN.
REQ-015 IDLE with enable=1: register load=1 and timer_value=duration of the current phase, then go to ARM.
REQ-016 ARM lasts exactly one cycle, deasserts load, then goes to RUN; counter_value is ignored in ARM.
REQ-017 RUN with counter_value!=0: hold state, load=0.
REQ-018 RUN with counter_value==0: advance phase RED->GREEN->YELLOW->RED, register load=1 and timer_value=duration of the new phase, then go to ARM.
REQ-019 Each phase is visible on the outputs for exactly duration+2 cycles in steady state.
REQ-020 enable falling in ARM or RUN: go to IDLE on the next edge, keep the phase, force load=0; re-enabling reloads the full duration of that phase.
REQ-021 Exactly one lamp is high at all times; lamps and phase change on the same edge.
REQ-022 load is never high for two consecutive cycles.

Reset
REQ-023 While reset is high: state=IDLE, phase=RED, red=1, yellow=0, green=0, load=0, timer_value=RED_TIME.
REQ-024 Reset mid-phase aborts the phase immediately; the first load after release carries RED_TIME.

Configuration
REQ-025 With PED_REQ_EN defined, add port ped_req (input, 1 bit) and port walk (output, 1 bit, reset 0).
REQ-026 With PED_REQ_EN, a ped_req high in any cycle sets a sticky latch.
REQ-027 With PED_REQ_EN, latch set in RUN/GREEN with counter_value>PED_SHORT: register load=1, timer_value=PED_SHORT, stay in GREEN, go to ARM; at most once per GREEN phase.
REQ-028 With PED_REQ_EN, on entry to RED with the latch set: clear the latch and drive walk=1 for the whole RED phase.
REQ-029 Without PED_REQ_EN, neither port nor any pedestrian logic exists, and behaviour is REQ-013..REQ-024 only.

Structure
REQ-030 Package light_pkg holds the phase encoding typedef, the FSM state typedef, the 6-bit timer width constant and the default durations.
REQ-031 Sub-module lamp_decoder (phase to registered one-hot red/yellow/green) is the single natural split; everything else stays in light_sequencer.

Verification
REQ-032 Reset high 3 cycles, enable=0 -> red=1, load=0, timer_value=18 throughout.
REQ-033 enable=1 after reset, with the counter model attached -> load pulses carry 18, 15, 3, 18 in order; phases last 20, 17 and 5 cycles.
REQ-034 enable dropped 4 cycles into GREEN, raised 10 cycles later -> GREEN is held, then load=1 with timer_value=15.
REQ-035 Reset asserted mid-YELLOW, asynchronously to clk -> red=1 immediately; first load after release carries 18.
REQ-036 PED_REQ_EN defined, ped_req pulse while GREEN counter_value=12 -> load with timer_value=5; following RED has walk=1 for 20 cycles.
REQ-037 PED_REQ_EN defined, ped_req pulse while GREEN counter_value=4 -> no extra load; walk=1 in the next RED.
